// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty decodes and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module fifo_sync_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 2,
    parameter int AF_MARGIN   = 1,
    parameter int AE_MARGIN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [INDEX_WIDTH:0]  count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam int CW    = INDEX_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL    = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL    = CW'(AE_MARGIN);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [INDEX_WIDTH-1:0] wr_ptr;
    logic [INDEX_WIDTH-1:0] rd_ptr;
    logic                   wr_acc;
    logic                   rd_acc;

    always_comb begin
        full         = (count == DEPTH_LVL);
        empty        = (count == '0);
        almost_full  = (count >= AF_LVL);
        almost_empty = (count <= AE_LVL);
        rd_acc       = rd_en && !empty;
        // A pop in the same cycle frees the slot, so a write at full is still taken.
        wr_acc       = wr_en && (!full || rd_acc);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Masked when empty so the output reads zero out of reset instead of stale storage.
    always_comb begin
        rd_valid = !empty;
        rd_data  = empty ? '0 : mem[rd_ptr];
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param (DEPTH=2): constant vector table, corner sequences and random traffic
// checked against a queue-based reference model. Honours FIFO_FWFT_EN like the design.
module tb_fifo_sync_param;

    localparam int DW    = 8;
    localparam int IW    = 1;
    localparam int DEPTH = 2;
    localparam int AFM   = 1;
    localparam int AEM   = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [IW:0]   count;
    logic          overflow;
    logic          underflow;

    fifo_sync_param #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW),
        .AF_MARGIN  (AFM),
        .AE_MARGIN  (AEM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    bit            m_valid;
    logic [DW-1:0] m_data;

    typedef struct {
        bit            wr;
        logic [DW-1:0] data;
        bit            rd;
        bit            clr;
        int            cnt;
        bit            ovf;
        bit            unf;
        bit            pop;
        logic [DW-1:0] pop_data;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - AFM));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEM));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
        chk("rd_valid", 32'(rd_valid), 32'(n > 0));
        chk("rd_data", 32'(rd_data), (n > 0) ? 32'(q[0]) : 32'd0);
`else
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", 32'(rd_data), 32'(m_data));
`endif
    endtask

    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bit rok;
        bit wok;
        logic [DW-1:0] tmp;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        rok = r && (q.size() > 0);
        wok = w && ((q.size() < DEPTH) || rok);
        if (w && !wok) m_ovf = 1'b1;
        else if (c)    m_ovf = 1'b0;
        if (r && q.size() == 0) m_unf = 1'b1;
        else if (c)             m_unf = 1'b0;
        m_valid = rok;
        if (rok) begin
            m_data = q[0];
            tmp = q.pop_front();
        end
        if (wok) q.push_back(d);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        model_check();
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // Pop check independent of the model: FWFT shows the head before the edge,
    // registered mode shows it after.
    task automatic pop_step(input string name, input bit w, input logic [DW-1:0] d,
                            input bit r, input bit expect_pop, input logic [DW-1:0] pd);
`ifdef FIFO_FWFT_EN
        if (expect_pop) begin
            chk({name, "_valid"}, 32'(rd_valid), 32'd1);
            chk({name, "_data"}, 32'(rd_data), 32'(pd));
        end
        step(w, d, r, 1'b0);
`else
        step(w, d, r, 1'b0);
        if (expect_pop) begin
            chk({name, "_valid"}, 32'(rd_valid), 32'd1);
            chk({name, "_data"}, 32'(rd_data), 32'(pd));
        end
`endif
    endtask

    initial begin
        tbl[0]  = '{1, 8'hA5, 0, 0, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 8'h3C, 0, 0, 2, 0, 0, 0, 8'h00};
        tbl[2]  = '{1, 8'hFF, 0, 0, 2, 1, 0, 0, 8'h00};
        tbl[3]  = '{0, 8'h00, 0, 1, 2, 0, 0, 0, 8'h00};
        tbl[4]  = '{0, 8'h00, 1, 0, 1, 0, 0, 1, 8'hA5};
        tbl[5]  = '{0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h3C};
        tbl[6]  = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00};
        tbl[7]  = '{0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h00};
        tbl[8]  = '{0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00};
        tbl[9]  = '{1, 8'h01, 0, 0, 1, 0, 0, 0, 8'h00};
        tbl[10] = '{1, 8'h02, 0, 0, 2, 0, 0, 0, 8'h00};
        tbl[11] = '{1, 8'h11, 1, 0, 2, 0, 0, 1, 8'h01};
        tbl[12] = '{0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h02};
        tbl[13] = '{0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h11};
        tbl[14] = '{1, 8'h22, 1, 0, 1, 0, 1, 0, 8'h00};
        tbl[15] = '{0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00};
        tbl[16] = '{0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h22};

        model_reset();
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        model_check();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // fill/drain, overflow, underflow, simultaneous at full and empty
        for (int i = 0; i < 17; i++) begin
`ifdef FIFO_FWFT_EN
            if (tbl[i].pop) begin
                chk("tbl_pop_valid", 32'(rd_valid), 32'd1);
                chk("tbl_pop_data", 32'(rd_data), 32'(tbl[i].pop_data));
            end
            step(tbl[i].wr, tbl[i].data, tbl[i].rd, tbl[i].clr);
`else
            step(tbl[i].wr, tbl[i].data, tbl[i].rd, tbl[i].clr);
            if (tbl[i].pop) begin
                chk("tbl_pop_valid", 32'(rd_valid), 32'd1);
                chk("tbl_pop_data", 32'(rd_data), 32'(tbl[i].pop_data));
            end
`endif
            chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
            chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
            chk("tbl_underflow", 32'(underflow), 32'(tbl[i].unf));
        end

        // wrap: back-to-back write/read pairs
        for (int i = 0; i < 10; i++) begin
            pop_step("wrap", 1'b1, 8'(i), i > 0, i > 0, 8'(i - 1));
            chk("wrap_count_max", 32'(count > 2'd2 ? 1 : 0), 32'd0);
        end
        pop_step("wrap", 1'b0, 8'h00, 1'b1, 1'b1, 8'h09);

        // asynchronous reset mid-cycle with two entries held
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h6B, 1'b0, 1'b0);
        step(1'b1, 8'h7C, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_full", 32'(full), 32'd0);
        chk("async_rst_overflow", 32'(overflow), 32'd0);
        model_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_check();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
